// File: rtl/iram_uart_loader.sv
// UART-fed instruction RAM loader: receives a framed program image and writes
// 24-bit words into the iRAM while holding the CPU off through load_active.
module iram_uart_loader #(
    parameter int         CLK_FREQ       = 100000000,
    parameter int         BAUD           = 115200,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 2000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx,
    output logic        load_active,
    output logic        iram_we,
    output logic [7:0]  iram_addr,
    output logic [23:0] iram_data,
    output logic [7:0]  words_written,
    output logic        done,
    output logic        error
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int BW           = $clog2(CLKS_PER_BIT + 1);
    localparam int TW           = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {IDLE, COUNT, DATA, CHECK} state_t;

    rx_state_t     rx_state, rx_state_next;
    logic          rx_meta, rx_sync, rx_prev;
    logic [BW-1:0] bit_cnt, bit_cnt_next;
    logic [2:0]    bit_idx, bit_idx_next;
    logic [7:0]    rx_byte, rx_byte_next;
    logic          byte_valid, byte_valid_next;
    logic          frame_err, frame_err_next;

    state_t        state, state_next;
    logic [8:0]    remaining, remaining_next;
    logic [1:0]    byte_idx, byte_idx_next;
    logic [15:0]   assembly, assembly_next;
    logic [7:0]    checksum, checksum_next;
    logic [TW-1:0] tcnt, tcnt_next;
    logic          load_next, we_next, done_next, error_next;
    logic [7:0]    addr_next, words_next;
    logic [23:0]   data_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta       <= 1'b1;
            rx_sync       <= 1'b1;
            rx_prev       <= 1'b1;
            rx_state      <= RX_IDLE;
            bit_cnt       <= '0;
            bit_idx       <= '0;
            rx_byte       <= '0;
            byte_valid    <= 1'b0;
            frame_err     <= 1'b0;
            state         <= IDLE;
            remaining     <= '0;
            byte_idx      <= '0;
            assembly      <= '0;
            checksum      <= '0;
            tcnt          <= '0;
            load_active   <= 1'b0;
            iram_we       <= 1'b0;
            iram_addr     <= '0;
            iram_data     <= '0;
            words_written <= '0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            rx_meta       <= uart_rx;
            rx_sync       <= rx_meta;
            rx_prev       <= rx_sync;
            rx_state      <= rx_state_next;
            bit_cnt       <= bit_cnt_next;
            bit_idx       <= bit_idx_next;
            rx_byte       <= rx_byte_next;
            byte_valid    <= byte_valid_next;
            frame_err     <= frame_err_next;
            state         <= state_next;
            remaining     <= remaining_next;
            byte_idx      <= byte_idx_next;
            assembly      <= assembly_next;
            checksum      <= checksum_next;
            tcnt          <= tcnt_next;
            load_active   <= load_next;
            iram_we       <= we_next;
            iram_addr     <= addr_next;
            iram_data     <= data_next;
            words_written <= words_next;
            done          <= done_next;
            error         <= error_next;
        end
    end

    // Receiver: start bit re-checked at half a bit, then every sample lands mid-bit.
    always_comb begin
        rx_state_next   = rx_state;
        bit_cnt_next    = bit_cnt;
        bit_idx_next    = bit_idx;
        rx_byte_next    = rx_byte;
        byte_valid_next = 1'b0;
        frame_err_next  = 1'b0;
        unique case (rx_state)
            RX_IDLE: begin
                bit_cnt_next = '0;
                if (rx_prev && !rx_sync) rx_state_next = RX_START;
            end
            RX_START: begin
                if (bit_cnt == BW'(HALF_BIT - 1)) begin
                    bit_cnt_next  = '0;
                    bit_idx_next  = '0;
                    rx_state_next = rx_sync ? RX_IDLE : RX_DATA;
                end else begin
                    bit_cnt_next = bit_cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (bit_cnt == BW'(CLKS_PER_BIT - 1)) begin
                    bit_cnt_next = '0;
                    rx_byte_next = {rx_sync, rx_byte[7:1]};
                    bit_idx_next = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) rx_state_next = RX_STOP;
                end else begin
                    bit_cnt_next = bit_cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (bit_cnt == BW'(CLKS_PER_BIT - 1)) begin
                    bit_cnt_next    = '0;
                    byte_valid_next = rx_sync;
                    frame_err_next  = !rx_sync;
                    rx_state_next   = RX_IDLE;
                end else begin
                    bit_cnt_next = bit_cnt + 1'b1;
                end
            end
        endcase
    end

    // Frame parser; the address/count advance happens in the strobe cycle's successor.
    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        byte_idx_next  = byte_idx;
        assembly_next  = assembly;
        checksum_next  = checksum;
        load_next      = load_active;
        we_next        = 1'b0;
        addr_next      = iram_addr;
        data_next      = iram_data;
        words_next     = words_written;
        done_next      = done;
        error_next     = error;
        if (state == IDLE || byte_valid) tcnt_next = '0;
        else                             tcnt_next = tcnt + 1'b1;
        unique case (state)
            IDLE: begin
                if (byte_valid && rx_byte == SYNC_BYTE) begin
                    state_next    = COUNT;
                    load_next     = 1'b1;
                    done_next     = 1'b0;
                    error_next    = 1'b0;
                    words_next    = '0;
                    addr_next     = '0;
                    checksum_next = '0;
                end
            end
            COUNT: begin
                if (byte_valid) begin
                    remaining_next = (rx_byte == 8'h00) ? 9'h100 : {1'b0, rx_byte};
                    checksum_next  = checksum ^ rx_byte;
                    byte_idx_next  = '0;
                    state_next     = DATA;
                end
            end
            DATA: begin
                if (byte_valid) begin
                    assembly_next = {assembly[7:0], rx_byte};
                    checksum_next = checksum ^ rx_byte;
                    if (byte_idx == 2'd2) begin
                        we_next   = 1'b1;
                        data_next = {assembly, rx_byte};
                    end else begin
                        byte_idx_next = byte_idx + 1'b1;
                    end
                end
                if (iram_we) begin
                    addr_next      = iram_addr + 1'b1;
                    words_next     = words_written + 1'b1;
                    remaining_next = remaining - 1'b1;
                    byte_idx_next  = '0;
                    if (remaining == 9'd1) state_next = CHECK;
                end
            end
            CHECK: begin
                if (byte_valid) begin
                    if (rx_byte == checksum) done_next  = 1'b1;
                    else                     error_next = 1'b1;
                    state_next = IDLE;
                    load_next  = 1'b0;
                end
            end
        endcase
        if (state != IDLE && (frame_err || (!byte_valid && tcnt == TW'(TIMEOUT_CYCLES - 1)))) begin
            error_next = 1'b1;
            load_next  = 1'b0;
            state_next = IDLE;
        end
    end
endmodule
